// File: rtl/bp_defs.sv
// ============================================================================
// Module      : bp_defs
// Description : Shared constants and helpers for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package bp_defs;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam int PC_STEP = 2;

    // Saturating 2-bit direction counter update for a conditional branch
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, mispredict resolve
//               and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module branch_predictor
    import bp_defs::*;
#(
    parameter int DBITS   = 16,
    parameter int ENTRIES = 16,
    parameter int CNTBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DBITS-1:0]   f_pc,
    output logic               f_hit,
    output logic               f_pred_taken,
    output logic [DBITS-1:0]   f_pred_target,
    input  logic               u_valid,
    input  logic               u_jmp,
    input  logic [DBITS-1:0]   u_pc,
    input  logic               u_taken,
    input  logic [DBITS-1:0]   u_target,
    input  logic               u_pred_taken,
    input  logic [DBITS-1:0]   u_pred_target,
    output logic               mispredict,
    output logic [DBITS-1:0]   redirect_pc,
    output logic [CNTBITS-1:0] stat_branches,
    output logic [CNTBITS-1:0] stat_mispred,
    input  logic               stat_clr
);

    localparam int IDXBITS = $clog2(ENTRIES);
    localparam int TAGBITS = DBITS - IDXBITS - 1;

    // Valid and counters need the asynchronous clear; tag/target do not
    logic               r_valid  [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAGBITS-1:0] r_tag    [ENTRIES];
    logic [DBITS-1:0]   r_target [ENTRIES];

    logic [IDXBITS-1:0] w_f_idx;
    logic [TAGBITS-1:0] w_f_tag;
    logic [IDXBITS-1:0] w_u_idx;
    logic [TAGBITS-1:0] w_u_tag;
    logic               w_u_hit;
    logic               w_taken;
    logic               w_mispredict;
    logic               w_unused;

    assign w_f_idx = f_pc[IDXBITS:1];
    assign w_f_tag = f_pc[DBITS-1:IDXBITS+1];
    assign w_u_idx = u_pc[IDXBITS:1];
    assign w_u_tag = u_pc[DBITS-1:IDXBITS+1];
    assign w_unused = &{1'b0, f_pc[0], u_pc[0]};

    // Fetch lookup
    assign f_hit         = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign f_pred_taken  = f_hit && r_ctr[w_f_idx][1];
    assign f_pred_target = f_pred_taken ? r_target[w_f_idx] : (f_pc + DBITS'(PC_STEP));

    // Resolve
    assign w_taken      = u_jmp | u_taken;
    assign w_mispredict = u_valid &&
                          ((w_taken != u_pred_taken) ||
                           (w_taken && (u_target != u_pred_target)));
    assign mispredict   = w_mispredict;
    assign redirect_pc  = !u_valid ? '0 :
                          (w_taken ? u_target : (u_pc + DBITS'(PC_STEP)));

    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_SNT;
            end
        end else if (u_valid) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= u_jmp ? CTR_ST : ctr_update(r_ctr[w_u_idx], w_taken);
            end else if (w_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= u_jmp ? CTR_ST : CTR_WT;
            end
        end
    end

    // Any taken outcome writes target; on a hit the tag rewrite is a no-op
    always_ff @(posedge clk) begin
        if (u_valid && w_taken) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= u_target;
        end
    end

    sat_counter #(.W(CNTBITS)) u_stat_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (u_valid),
        .q     (stat_branches)
    );

    sat_counter #(.W(CNTBITS)) u_stat_mispred (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (w_mispredict),
        .q     (stat_mispred)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed scoreboard bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_branch_predictor;

    localparam int DBITS   = 16;
    localparam int ENTRIES = 16;
    localparam int CNTBITS = 4;

    localparam int S_HIT   = 0;
    localparam int S_PT    = 1;
    localparam int S_PTGT  = 2;
    localparam int S_MISP  = 3;
    localparam int S_REDIR = 4;
    localparam int S_SB    = 5;
    localparam int S_SM    = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DBITS-1:0]   f_pc = '0;
    logic               f_hit;
    logic               f_pred_taken;
    logic [DBITS-1:0]   f_pred_target;
    logic               u_valid = 1'b0;
    logic               u_jmp = 1'b0;
    logic [DBITS-1:0]   u_pc = '0;
    logic               u_taken = 1'b0;
    logic [DBITS-1:0]   u_target = '0;
    logic               u_pred_taken = 1'b0;
    logic [DBITS-1:0]   u_pred_target = '0;
    logic               mispredict;
    logic [DBITS-1:0]   redirect_pc;
    logic [CNTBITS-1:0] stat_branches;
    logic [CNTBITS-1:0] stat_mispred;
    logic               stat_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    branch_predictor #(.DBITS(DBITS), .ENTRIES(ENTRIES), .CNTBITS(CNTBITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_pc          (f_pc),
        .f_hit         (f_hit),
        .f_pred_taken  (f_pred_taken),
        .f_pred_target (f_pred_target),
        .u_valid       (u_valid),
        .u_jmp         (u_jmp),
        .u_pc          (u_pc),
        .u_taken       (u_taken),
        .u_target      (u_target),
        .u_pred_taken  (u_pred_taken),
        .u_pred_target (u_pred_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred),
        .stat_clr      (stat_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_HIT:   return 32'(f_hit);
            S_PT:    return 32'(f_pred_taken);
            S_PTGT:  return 32'(f_pred_target);
            S_MISP:  return 32'(mispredict);
            S_REDIR: return 32'(redirect_pc);
            S_SB:    return 32'(stat_branches);
            default: return 32'(stat_mispred);
        endcase
    endfunction

    task automatic push(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sig);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=0x%0h expected=0x%0h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic set_upd(input logic jmp, input logic [15:0] pc, input logic taken,
                           input logic [15:0] tgt, input logic pt, input logic [15:0] ptgt);
        u_valid       = 1'b1;
        u_jmp         = jmp;
        u_pc          = pc;
        u_taken       = taken;
        u_target      = tgt;
        u_pred_taken  = pt;
        u_pred_target = ptgt;
    endtask

    // One resolve cycle: check combinational outputs, then let it train
    task automatic upd(input string name, input logic jmp, input logic [15:0] pc,
                       input logic taken, input logic [15:0] tgt, input logic pt,
                       input logic [15:0] ptgt, input logic e_misp, input logic [15:0] e_redir);
        @(negedge clk);
        set_upd(jmp, pc, taken, tgt, pt, ptgt);
        #1;
        push({name, ".misp"}, S_MISP, 32'(e_misp));
        push({name, ".redir"}, S_REDIR, 32'(e_redir));
        check_all();
        @(posedge clk);
        #1;
        u_valid = 1'b0;
    endtask

    task automatic look(input string name, input logic [15:0] pc, input logic e_hit,
                        input logic e_pt, input logic [15:0] e_tgt);
        @(negedge clk);
        u_valid = 1'b0;
        f_pc    = pc;
        #1;
        push({name, ".hit"}, S_HIT, 32'(e_hit));
        push({name, ".ptaken"}, S_PT, 32'(e_pt));
        push({name, ".ptgt"}, S_PTGT, 32'(e_tgt));
        check_all();
    endtask

    task automatic stats(input string name, input int e_b, input int e_m);
        push({name, ".branches"}, S_SB, 32'(e_b));
        push({name, ".mispred"}, S_SM, 32'(e_m));
        check_all();
    endtask

    initial begin
        #12 rst_n = 1'b1;

        // Cold lookup and idle resolve outputs
        look("cold", 16'h0200, 1'b0, 1'b0, 16'h0202);
        push("idle.misp", S_MISP, 32'd0);
        push("idle.redir", S_REDIR, 32'd0);
        check_all();
        stats("reset", 0, 0);

        // First taken branch, with same-cycle lookup seeing old contents
        @(negedge clk);
        f_pc = 16'h0204;
        set_upd(1'b0, 16'h0204, 1'b1, 16'h0240, 1'b0, 16'h0206);
        #1;
        push("first.misp", S_MISP, 32'd1);
        push("first.redir", S_REDIR, 32'h0240);
        push("nobypass.hit", S_HIT, 32'd0);
        push("nobypass.ptgt", S_PTGT, 32'h0206);
        check_all();
        @(posedge clk);
        #1;
        u_valid = 1'b0;
        look("alloc", 16'h0204, 1'b1, 1'b1, 16'h0240);
        stats("s1", 1, 1);

        // Hysteresis down: 2 -> 1 -> 0
        upd("nt1", 1'b0, 16'h0204, 1'b0, 16'h0240, 1'b1, 16'h0240, 1'b1, 16'h0206);
        look("ctr1", 16'h0204, 1'b1, 1'b0, 16'h0206);
        upd("nt2", 1'b0, 16'h0204, 1'b0, 16'h0240, 1'b0, 16'h0206, 1'b0, 16'h0206);
        look("ctr0", 16'h0204, 1'b1, 1'b0, 16'h0206);
        stats("s3", 3, 2);

        // Back up: 0 -> 1 (still not taken) -> 2 -> 3 -> 3, then down to 2
        upd("t1", 1'b0, 16'h0204, 1'b1, 16'h0240, 1'b0, 16'h0206, 1'b1, 16'h0240);
        look("ctr1b", 16'h0204, 1'b1, 1'b0, 16'h0206);
        upd("t2", 1'b0, 16'h0204, 1'b1, 16'h0240, 1'b0, 16'h0206, 1'b1, 16'h0240);
        look("ctr2", 16'h0204, 1'b1, 1'b1, 16'h0240);
        upd("t3", 1'b0, 16'h0204, 1'b1, 16'h0240, 1'b1, 16'h0240, 1'b0, 16'h0240);
        upd("badtgt", 1'b0, 16'h0204, 1'b1, 16'h0240, 1'b1, 16'h0250, 1'b1, 16'h0240);
        upd("nt3", 1'b0, 16'h0204, 1'b0, 16'h0240, 1'b1, 16'h0240, 1'b1, 16'h0206);
        look("sat3", 16'h0204, 1'b1, 1'b1, 16'h0240);
        stats("s8", 8, 6);

        // Aliasing on index 2
        upd("alias", 1'b0, 16'h0224, 1'b1, 16'h0100, 1'b0, 16'h0226, 1'b1, 16'h0100);
        look("evicted", 16'h0204, 1'b0, 1'b0, 16'h0206);
        look("alias", 16'h0224, 1'b1, 1'b1, 16'h0100);
        upd("ntmiss", 1'b0, 16'h0264, 1'b0, 16'h0900, 1'b0, 16'h0266, 1'b0, 16'h0266);
        look("kept", 16'h0224, 1'b1, 1'b1, 16'h0100);
        look("nomiss", 16'h0264, 1'b0, 1'b0, 16'h0266);
        stats("s10", 10, 7);

        // JMP allocates strongly taken: one not-taken leaves it predicted taken
        upd("jmp", 1'b1, 16'h0300, 1'b0, 16'h0500, 1'b0, 16'h0302, 1'b1, 16'h0500);
        look("jmp", 16'h0300, 1'b1, 1'b1, 16'h0500);
        upd("jmpnt", 1'b0, 16'h0300, 1'b0, 16'h0500, 1'b1, 16'h0500, 1'b1, 16'h0302);
        look("jmpctr", 16'h0300, 1'b1, 1'b1, 16'h0500);
        stats("s12", 12, 9);

        // Saturating stats
        for (int i = 0; i < 20; i++)
            upd("mloop", 1'b0, 16'h0400, 1'b1, 16'h0480, 1'b0, 16'h0402, 1'b1, 16'h0480);
        stats("sat", 15, 15);

        // Clear beats same-cycle increment
        @(negedge clk);
        set_upd(1'b0, 16'h0400, 1'b1, 16'h0480, 1'b0, 16'h0402);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        u_valid  = 1'b0;
        stat_clr = 1'b0;
        stats("clr", 0, 0);
        upd("postclr", 1'b0, 16'h0400, 1'b1, 16'h0480, 1'b1, 16'h0480, 1'b0, 16'h0480);
        stats("postclr", 1, 0);

        // Asynchronous reset pulse mid-cycle
        look("prerst", 16'h0224, 1'b1, 1'b1, 16'h0100);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #0.5;
        push("rst.hit", S_HIT, 32'd0);
        push("rst.ptgt", S_PTGT, 32'h0226);
        check_all();
        stats("rst", 0, 0);
        look("rst300", 16'h0300, 1'b0, 1'b0, 16'h0302);
        look("rst400", 16'h0400, 1'b0, 1'b0, 16'h0402);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
